// File: rtl/vector_ld_st_if.sv
// Bus between the CPU/memory side and the vector load/store unit.
// The master modport is the environment (CPU request plus memory read data);
// the slave modport is the load/store unit itself.
interface vector_ld_st_if #(
    parameter int WORD_W = 32,
    parameter int LANES  = 4
);
    logic                     mem_wen;
    logic                     mem_wen_v;
    logic [WORD_W-1:0]        mem_data;
    logic [WORD_W*LANES-1:0]  input_vector_A;
    logic [WORD_W*LANES-1:0]  input_vector_B;
    logic [WORD_W*LANES-1:0]  output_vector;
    logic                     stall_cpu;
    logic                     mem_wen_output;
    logic [WORD_W-1:0]        m_address;
    logic [WORD_W-1:0]        to_mem_data;

    modport master (
        output mem_wen, mem_wen_v, mem_data, input_vector_A, input_vector_B,
        input  output_vector, stall_cpu, mem_wen_output, m_address, to_mem_data
    );

    modport slave (
        input  mem_wen, mem_wen_v, mem_data, input_vector_A, input_vector_B,
        output output_vector, stall_cpu, mem_wen_output, m_address, to_mem_data
    );
endinterface

// File: rtl/vector_ld_st.sv
// Vector load/store unit: scalar accesses pass straight through to a
// single-port word memory; a vector access is split into LANES one-word
// beats while the CPU is stalled, and loaded lanes collect in output_vector.
module vector_ld_st #(
    parameter int WORD_W      = 32,
    parameter int LANES       = 4,
    parameter int ADDR_STRIDE = 4
) (
    input  logic          clk,
    input  logic          rst,
    vector_ld_st_if.slave bus
);
    localparam int VEC_W  = WORD_W * LANES;
    localparam int BEAT_W = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state_q;
    logic [BEAT_W-1:0] beat_q;
    logic [WORD_W-1:0] base_q;
    logic [VEC_W-1:0]  data_q;
    logic [VEC_W-1:0]  out_q;
    logic              op_store_q;
    logic [WORD_W-1:0] lane_data;
    logic [WORD_W-1:0] beat_addr;
    logic              unused_a_hi;

    // Only the low word of the address operand carries the base address.
    assign unused_a_hi = ^bus.input_vector_A[VEC_W-1:WORD_W];

    // Latched store-data lane for the current beat.
    always_comb begin
        lane_data = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            if (beat_q == BEAT_W'(i)) begin
                lane_data = data_q[i*WORD_W +: WORD_W];
            end
        end
    end

    // Lane address wraps modulo 2^WORD_W.
    assign beat_addr = base_q + WORD_W'(ADDR_STRIDE) * WORD_W'(beat_q);

    // Sequencer: latch the request, walk the beats, collect loaded lanes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            beat_q     <= '0;
            base_q     <= '0;
            data_q     <= '0;
            op_store_q <= 1'b0;
            out_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.mem_wen_v) begin
                        base_q     <= bus.input_vector_A[WORD_W-1:0];
                        data_q     <= bus.input_vector_B;
                        op_store_q <= bus.mem_wen;
                        beat_q     <= '0;
                        state_q    <= BUSY;
                    end
                end
                BUSY: begin
                    for (int unsigned i = 0; i < LANES; i++) begin
                        if (!op_store_q && beat_q == BEAT_W'(i)) begin
                            out_q[i*WORD_W +: WORD_W] <= bus.mem_data;
                        end
                    end
                    if (beat_q == BEAT_W'(LANES - 1)) begin
                        state_q <= DONE;
                    end else begin
                        beat_q <= beat_q + 1'b1;
                    end
                end
                DONE: begin
                    // A request still held here is ignored; it is taken up in IDLE.
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Memory-side outputs and CPU stall. The scalar path and the request
    // stall must react in the same cycle, so these decode the registered
    // state combinationally; reset forces them all low.
    always_comb begin
        bus.stall_cpu      = 1'b0;
        bus.mem_wen_output = 1'b0;
        bus.m_address      = '0;
        bus.to_mem_data    = '0;
        if (rst) begin
            case (state_q)
                IDLE: begin
                    if (bus.mem_wen_v) begin
                        bus.stall_cpu = 1'b1;
                    end else begin
                        bus.m_address      = bus.input_vector_A[WORD_W-1:0];
                        bus.to_mem_data    = bus.input_vector_B[WORD_W-1:0];
                        bus.mem_wen_output = bus.mem_wen;
                    end
                end
                BUSY: begin
                    bus.stall_cpu      = 1'b1;
                    bus.m_address      = beat_addr;
                    bus.mem_wen_output = op_store_q;
                    bus.to_mem_data    = op_store_q ? lane_data : '0;
                end
                DONE: begin
                    bus.m_address = base_q;
                end
                default: ;
            endcase
        end
    end

    assign bus.output_vector = out_q;
endmodule

// File: tb/tb_vector_ld_st.sv
// Directed bench for vector_ld_st. Stimulus drives one cycle at a time and
// queues the outputs expected for that cycle; a negedge monitor pops and
// compares. Memory model: read data = 32'h1000 + m_address.
module tb_vector_ld_st;
    logic clk = 1'b0;
    logic rst = 1'b0;

    vector_ld_st_if #(.WORD_W(32), .LANES(4)) bus ();

    vector_ld_st #(.WORD_W(32), .LANES(4), .ADDR_STRIDE(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    assign bus.mem_data = 32'h1000 + bus.m_address;

    typedef struct {
        string        name;
        logic         stall;
        logic         wen;
        logic [31:0]  addr;
        bit           ca;
        logic [31:0]  wdata;
        bit           cd;
        logic [127:0] ov;
        bit           cov;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;

    localparam logic [127:0] LOADV  = {32'h120C, 32'h1208, 32'h1204, 32'h1200};
    localparam logic [127:0] WRAPV  = {32'h1004, 32'h1000, 32'h0FFC, 32'h0FF8};
    localparam logic [127:0] STOREB = 128'h44444444_33333333_22222222_11111111;

    task automatic chk(input string n, input string f, input logic [127:0] act, input logic [127:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s.%s: got %h expected %h", n, f, act, want);
        end
    endtask

    // Monitor: one expected record per cycle, compared mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk(e.name, "stall_cpu", 128'(bus.stall_cpu), 128'(e.stall));
            chk(e.name, "mem_wen_output", 128'(bus.mem_wen_output), 128'(e.wen));
            if (e.ca)  chk(e.name, "m_address", 128'(bus.m_address), 128'(e.addr));
            if (e.cd)  chk(e.name, "to_mem_data", 128'(bus.to_mem_data), 128'(e.wdata));
            if (e.cov) chk(e.name, "output_vector", bus.output_vector, e.ov);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string n, input logic s, input logic w,
                        input logic [31:0] a, input bit ca,
                        input logic [31:0] d, input bit cd,
                        input logic [127:0] ov, input bit cov);
        exp_t x;
        x.name = n; x.stall = s; x.wen = w; x.addr = a; x.ca = ca;
        x.wdata = d; x.cd = cd; x.ov = ov; x.cov = cov;
        exp_q.push_back(x);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.mem_wen        = 1'b1;
        bus.mem_wen_v      = 1'b1;
        bus.input_vector_A = 128'hFFFF_0000_FFFF_0000_FFFF_0000_ABCD_1234;
        bus.input_vector_B = 128'h5A5A_5A5A_5A5A_5A5A_5A5A_5A5A_5A5A_5A5A;

        // Reset with arbitrary inputs
        step();
        push("reset", 0, 0, 32'h0, 1, 32'h0, 1, '0, 1);

        // Release, idle scalar read path
        step();
        rst = 1'b1; bus.mem_wen = 0; bus.mem_wen_v = 0;
        bus.input_vector_A = {96'h0, 32'h50}; bus.input_vector_B = {96'h0, 32'h77};
        push("idle", 0, 0, 32'h50, 1, 32'h77, 1, '0, 1);

        // Scalar store
        step();
        bus.input_vector_A = {96'h0, 32'h100}; bus.input_vector_B = {96'h0, 32'h00AA}; bus.mem_wen = 1;
        push("scalar_st", 0, 1, 32'h100, 1, 32'h00AA, 1, '0, 1);
        step();
        bus.mem_wen = 0;
        push("scalar_rd", 0, 0, 32'h100, 1, 32'h00AA, 1, '0, 1);

        // Vector load at 0x200; operands scrambled during the beats
        step();
        bus.input_vector_A = {96'h0, 32'h200}; bus.mem_wen = 0; bus.mem_wen_v = 1;
        push("vld_req", 1, 0, 32'h0, 0, 32'h0, 0, '0, 1);
        step();
        bus.input_vector_A = {96'h0, 32'hDEAD0000}; bus.mem_wen = 1;
        bus.input_vector_B = {96'h0, 32'hCAFEF00D};
        push("vld_b0", 1, 0, 32'h200, 1, 32'h0, 1, '0, 1);
        step();
        push("vld_b1", 1, 0, 32'h204, 1, 32'h0, 1, {96'h0, 32'h1200}, 1);
        step();
        push("vld_b2", 1, 0, 32'h208, 1, 32'h0, 1, {64'h0, 32'h1204, 32'h1200}, 1);
        step();
        push("vld_b3", 1, 0, 32'h20C, 1, 32'h0, 1, {32'h0, 32'h1208, 32'h1204, 32'h1200}, 1);
        step();
        bus.mem_wen_v = 0;
        push("vld_done", 0, 0, 32'h200, 1, 32'h0, 1, LOADV, 1);
        step();
        bus.mem_wen = 0;
        push("vld_noretrig", 0, 0, 32'hDEAD0000, 1, 32'hCAFEF00D, 1, LOADV, 1);

        // Vector store at 0x300; request held through DONE
        step();
        bus.input_vector_A = {96'h0, 32'h300}; bus.input_vector_B = STOREB;
        bus.mem_wen = 1; bus.mem_wen_v = 1;
        push("vst_req", 1, 0, 32'h0, 0, 32'h0, 0, LOADV, 1);
        step();
        bus.input_vector_B = '1; bus.mem_wen = 0;
        push("vst_b0", 1, 1, 32'h300, 1, 32'h11111111, 1, LOADV, 1);
        step();
        push("vst_b1", 1, 1, 32'h304, 1, 32'h22222222, 1, LOADV, 1);
        step();
        push("vst_b2", 1, 1, 32'h308, 1, 32'h33333333, 1, LOADV, 1);
        step();
        push("vst_b3", 1, 1, 32'h30C, 1, 32'h44444444, 1, LOADV, 1);
        step();
        bus.input_vector_A = {96'h0, 32'hFFFFFFF8};
        push("vst_done_held", 0, 0, 32'h300, 1, 32'h0, 1, LOADV, 1);

        // Held request restarts from IDLE: wrapping vector load
        step();
        push("wrap_req", 1, 0, 32'h0, 0, 32'h0, 0, LOADV, 1);
        step();
        push("wrap_b0", 1, 0, 32'hFFFFFFF8, 1, 32'h0, 1, LOADV, 1);
        step();
        push("wrap_b1", 1, 0, 32'hFFFFFFFC, 1, 32'h0, 1, {32'h120C, 32'h1208, 32'h1204, 32'h0FF8}, 1);
        step();
        push("wrap_b2", 1, 0, 32'h00000000, 1, 32'h0, 1, {32'h120C, 32'h1208, 32'h0FFC, 32'h0FF8}, 1);
        step();
        push("wrap_b3", 1, 0, 32'h00000004, 1, 32'h0, 1, {32'h120C, 32'h1000, 32'h0FFC, 32'h0FF8}, 1);
        step();
        bus.mem_wen_v = 0;
        push("wrap_done", 0, 0, 32'hFFFFFFF8, 1, 32'h0, 1, WRAPV, 1);

        // Load aborted by reset after beat 1
        step();
        bus.input_vector_A = {96'h0, 32'h400}; bus.mem_wen_v = 1;
        push("abort_req", 1, 0, 32'h0, 0, 32'h0, 0, WRAPV, 1);
        step();
        push("abort_b0", 1, 0, 32'h400, 1, 32'h0, 1, WRAPV, 1);
        step();
        push("abort_b1", 1, 0, 32'h404, 1, 32'h0, 1, {32'h1004, 32'h1000, 32'h0FFC, 32'h1400}, 1);
        step();
        rst = 1'b0;
        push("abort_rst", 0, 0, 32'h0, 1, 32'h0, 1, '0, 1);
        step();
        rst = 1'b1; bus.mem_wen_v = 0; bus.mem_wen = 0;
        bus.input_vector_A = {96'h0, 32'h500}; bus.input_vector_B = {96'h0, 32'h55};
        push("abort_idle", 0, 0, 32'h500, 1, 32'h55, 1, '0, 1);

        step();
        step();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expectations expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/vector_ld_st.md
Name: vector_ld_st

Overview:
Vector load/store unit between the vector register file and a 32-bit single-port data memory. It passes scalar stores straight through. A 128-bit vector access is serialized into four 32-bit memory beats, and the CPU is stalled for the duration. Vector load results are assembled into a 128-bit output register.

Parameters:
WORD_W, 32, memory word width and lane width
LANES, 4, lanes per vector (vector width = WORD_W*LANES = 128)
ADDR_STRIDE, 4, byte address increment between consecutive lanes

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  reset, asynchronous, active-low (rst=0 resets)
mem_wen  input  1  scalar store request; during a vector request, selects store (1) vs load (0)
mem_wen_v  input  1  vector access request, held by CPU until stall_cpu falls
mem_data  input  32  memory read data, combinational for the current m_address
input_vector_A  input  128  address operand; base address = bits [31:0]
input_vector_B  input  128  store data; lane i = bits [32i+31:32i]
output_vector  output  128  vector load result register
stall_cpu  output  1  CPU stall while a vector access is in progress
mem_wen_output  output  1  memory write enable
m_address  output  32  memory byte address
to_mem_data  output  32  memory write data

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, beat counter=0, latched base/data/op=0, output_vector=0.
  - Outputs forced low: stall_cpu=0, mem_wen_output=0, m_address=0, to_mem_data=0.
- Lane order: lane i = bits [32i+31:32i]. Lane 0 is at the base address; lane i is at base+4*i, modulo 2^32 (address wraps, no error).
- States: IDLE, BUSY (beat 0..3), DONE.
- IDLE, mem_wen_v=0 (scalar path, combinational):
  - m_address=A[31:0], to_mem_data=B[31:0], mem_wen_output=mem_wen, stall_cpu=0.
  - output_vector holds its value.
- IDLE, mem_wen_v=1:
  - stall_cpu=1 combinationally in the same cycle; mem_wen_output=0.
  - On the next rising edge: latch base=A[31:0], store data=B, op=mem_wen (1=store, 0=load); go to BUSY beat 0.
- BUSY beat k (k=0..3):
  - stall_cpu=1, m_address=base+4*k.
  - Store: mem_wen_output=1, to_mem_data=latched B lane k.
  - Load: mem_wen_output=0, to_mem_data=0; on the rising edge, output_vector lane k <= mem_data. Other lanes hold.
  - After k=3, go to DONE.
- DONE (one cycle):
  - stall_cpu=0, mem_wen_output=0, m_address=base, to_mem_data=0.
  - output_vector holds the complete loaded vector.
  - mem_wen_v is ignored, so a request still high while the CPU advances does not retrigger. Next state is IDLE.
- Latency: the request is seen in cycle 0; the CPU is stalled for 5 cycles (request cycle + 4 beats) and released in DONE. The load result is valid from the start of DONE.
- mem_wen, A and B changing during BUSY/DONE have no effect; operands and op are latched.
- A vector store leaves output_vector unchanged.
- Reset mid-operation aborts immediately. Partially written memory beats are not rolled back. A partially loaded output_vector is cleared to 0.
- No back-pressure from memory: every beat completes in one cycle.

Test Plan:
- Reset: rst=0 with arbitrary inputs -> output_vector=0, stall_cpu=0, mem_wen_output=0; after rst=1, IDLE with mem_wen=0 -> m_address=A[31:0], mem_wen_output=0.
- Scalar store: A[31:0]=32'h100, B[31:0]=32'h00AA, mem_wen=1, mem_wen_v=0 -> same cycle m_address=32'h100, to_mem_data=32'h00AA, mem_wen_output=1, stall_cpu=0; mem_wen=0 -> mem_wen_output=0.
- Vector load: A[31:0]=32'h200, mem_wen=0, mem_wen_v=1, memory model returns 32'h1000+address:
  - stall_cpu high 5 cycles; m_address sequence 200, 204, 208, 20C.
  - In DONE: output_vector = {32'h120C, 32'h1208, 32'h1204, 32'h1200}, stall_cpu=0.
  - Drop mem_wen_v on stall negedge -> no retrigger.
- Vector store: B=128'h44444444_33333333_22222222_11111111, A[31:0]=32'h300, mem_wen=1, mem_wen_v=1:
  - 4 beats with mem_wen_output=1, addresses 300..30C, data 11111111, 22222222, 33333333, 44444444.
  - output_vector unchanged.
- Held request: keep mem_wen_v=1 through DONE for one cycle -> no new transfer in DONE; a new transfer starts only after the IDLE cycle with mem_wen_v still 1.
- Reset mid-load after beat 1: rst=0 -> stall_cpu=0 and output_vector=0 immediately (asynchronous); after release, IDLE.
- Address wrap: base 32'hFFFFFFF8 -> beat addresses FFFFFFF8, FFFFFFFC, 00000000, 00000004.
